// File: rtl/rename_alloc_ctrl_if.sv
// ============================================================================
// Module      : rename_alloc_ctrl_if
// Description : Bundle of rename-lane, commit-release, squash and free-list
//               signals shared by rename_alloc_ctrl and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rename_alloc_ctrl_if #(
    parameter int DATA_WIDTH = 7
);
    // Rename lanes
    logic                  req_1;
    logic                  req_2;
    logic                  grant_1;
    logic                  grant_2;
    logic [DATA_WIDTH-1:0] preg_1;
    logic [DATA_WIDTH-1:0] preg_2;
    // Commit releases
    logic                  rel_valid_1;
    logic [DATA_WIDTH-1:0] rel_data_1;
    logic                  rel_valid_2;
    logic [DATA_WIDTH-1:0] rel_data_2;
    logic                  rel_ready;
    // Flush / squash
    logic                  flush_start;
    logic                  squash_valid;
    logic [DATA_WIDTH-1:0] squash_data;
    logic                  squash_last;
    logic                  squash_ready;
    logic                  busy;
    // Free list
    logic                  fl_valid_1;
    logic                  fl_valid_2;
    logic [DATA_WIDTH-1:0] fl_pop_data_1;
    logic [DATA_WIDTH-1:0] fl_pop_data_2;
    logic                  fl_pop_1;
    logic                  fl_pop_2;
    logic                  fl_ready;
    logic                  fl_push;
    logic [DATA_WIDTH-1:0] fl_push_data;
    logic                  fl_push_2;
    logic [DATA_WIDTH-1:0] fl_push_data_2;

    // Controller side
    modport slave (
        input  req_1, req_2, rel_valid_1, rel_data_1, rel_valid_2, rel_data_2,
        input  flush_start, squash_valid, squash_data, squash_last,
        input  fl_valid_1, fl_valid_2, fl_pop_data_1, fl_pop_data_2, fl_ready,
        output grant_1, grant_2, preg_1, preg_2, rel_ready, squash_ready, busy,
        output fl_pop_1, fl_pop_2, fl_push, fl_push_data, fl_push_2, fl_push_data_2
    );

    // Pipeline / free-list side
    modport master (
        output req_1, req_2, rel_valid_1, rel_data_1, rel_valid_2, rel_data_2,
        output flush_start, squash_valid, squash_data, squash_last,
        output fl_valid_1, fl_valid_2, fl_pop_data_1, fl_pop_data_2, fl_ready,
        input  grant_1, grant_2, preg_1, preg_2, rel_ready, squash_ready, busy,
        input  fl_pop_1, fl_pop_2, fl_push, fl_push_data, fl_push_2, fl_push_data_2
    );
endinterface

`default_nettype wire

// File: rtl/rename_alloc_ctrl.sv
// ============================================================================
// Module      : rename_alloc_ctrl
// Description : Rename-stage controller for a dual-port physical register
//               free list: two in-order allocations per cycle, a release FIFO
//               draining into two push ports, and a RUN/FLUSH/DRAIN machine
//               that reclaims squashed tags before rename resumes.
//               Optional macro ALLOC_STATS_EN adds stall/flush cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_alloc_ctrl #(
    parameter int DATA_WIDTH     = 7,
    parameter int REL_FIFO_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rename_alloc_ctrl_if.slave    bus
`ifdef ALLOC_STATS_EN
    ,
    input  wire logic             stats_clr,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_cycles
`endif
);

    localparam int c_PTR_W = $clog2(REL_FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [REL_FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_run;
    logic [c_CNT_W-1:0]    w_free;
    logic                  w_rel_ready;
    logic                  w_acc_1;
    logic                  w_acc_2;
    logic [1:0]            w_n_commit;
    logic                  w_squash_ready;
    logic                  w_acc_sq;
    logic [1:0]            w_n_wr;
    logic                  w_push_1;
    logic                  w_push_2;
    logic [1:0]            w_n_push;
    logic [c_PTR_W-1:0]    w_addr_2;
    logic [c_PTR_W-1:0]    w_addr_sq;
    logic [c_PTR_W-1:0]    w_rd_ptr_nx;

    // Allocation, FIFO occupancy and write/drain decode
    always_comb begin
        w_run          = (r_state == S_RUN);
        w_free         = c_CNT_W'(REL_FIFO_DEPTH) - r_count;
        // Readiness uses only the registered count so it never depends on same-cycle drains
        w_rel_ready    = (w_free >= c_CNT_W'(2));
        w_acc_1        = bus.rel_valid_1 & w_rel_ready;
        w_acc_2        = bus.rel_valid_2 & w_rel_ready;
        w_n_commit     = {1'b0, w_acc_1} + {1'b0, w_acc_2};
        // Commit releases claim room first; a squash beat needs one slot beyond them
        w_squash_ready = (r_state == S_FLUSH) && (w_free > c_CNT_W'(w_n_commit));
        w_acc_sq       = bus.squash_valid & w_squash_ready;
        w_n_wr         = w_n_commit + {1'b0, w_acc_sq};
        w_push_1       = bus.fl_ready & (r_count != '0);
        w_push_2       = bus.fl_ready & (r_count >= c_CNT_W'(2));
        w_n_push       = {1'b0, w_push_1} + {1'b0, w_push_2};
        // Writes pack densely in slot order: slot 1, slot 2, then squash
        w_addr_2       = r_wr_ptr + c_PTR_W'(w_acc_1);
        w_addr_sq      = r_wr_ptr + c_PTR_W'(w_n_commit);
        w_rd_ptr_nx    = r_rd_ptr + c_PTR_W'(1);
    end

    // Output drive
    always_comb begin
        bus.grant_1        = bus.req_1 & bus.fl_valid_1 & w_run;
        bus.grant_2        = bus.req_2 & bus.req_1 & bus.fl_valid_2 & w_run;
        bus.fl_pop_1       = bus.grant_1;
        bus.fl_pop_2       = bus.grant_2;
        bus.preg_1         = bus.fl_pop_data_1;
        bus.preg_2         = bus.fl_pop_data_2;
        bus.rel_ready      = w_rel_ready;
        bus.squash_ready   = w_squash_ready;
        bus.busy           = ~w_run;
        bus.fl_push        = w_push_1;
        bus.fl_push_2      = w_push_2;
        bus.fl_push_data   = r_mem[r_rd_ptr];
        bus.fl_push_data_2 = r_mem[w_rd_ptr_nx];
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_acc_1)  r_mem[r_wr_ptr]  <= bus.rel_data_1;
        if (w_acc_2)  r_mem[w_addr_2]  <= bus.rel_data_2;
        if (w_acc_sq) r_mem[w_addr_sq] <= bus.squash_data;
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_n_wr);
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_n_push);
            r_count  <= r_count + c_CNT_W'(w_n_wr) - c_CNT_W'(w_n_push);
        end
    end

    // Flush state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_next;
    end

    // Flush next-state: reclaim squashed tags, then wait for the FIFO to empty
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (bus.flush_start) w_state_next = S_FLUSH;
            S_FLUSH: if (w_acc_sq && bus.squash_last) w_state_next = S_DRAIN;
            S_DRAIN: if ((r_count == '0) && (w_n_wr == 2'd0)) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

`ifdef ALLOC_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_cycles;

    // Saturating stall and busy-cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else if (stats_clr) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (bus.req_1 && !bus.grant_1 && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (!w_run && (r_flush_cycles != 16'hFFFF))
                r_flush_cycles <= r_flush_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

`default_nettype wire
